reduce_gate_pipe: RTL



---
 rtl/reduce_pkg.sv | 42 ++++
 rtl/reduce_node.sv | 28 ++
 rtl/reduce_gate_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/reduce_pkg.sv
`default_nettype none
// reduce_pkg: op encoding and elaboration helpers shared by the reduce_gate_pipe slice (rev 1.0).

package reduce_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } reduce_op_t;

  // Pad bit for short groups; NOR runs as an OR tree so it shares the OR identity.
  function automatic logic identity(input reduce_op_t op);
    return (op == OP_AND);
  endfunction

  function automatic int stages(input int n, input int radix);
    int s;
    int m;
    s = 0;
    m = n;
    while (m > 1) begin
      m = (m + radix - 1) / radix;
      s = s + 1;
    end
    return s;
  endfunction

  // Number of operands entering tree level k.
  function automatic int level_inputs(input int n, input int radix, input int k);
    int m;
    m = n;
    for (int i = 0; i < k; i++) begin
      m = (m + radix - 1) / radix;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reduce_node.sv
`default_nettype none
// reduce_node: combinational RADIX-input, WIDTH-wide bitwise reduction node (rev 1.0).

module reduce_node
  import reduce_pkg::*;
#(
  parameter int RADIX = 3,
  parameter int WIDTH = 4
) (
  input  logic [RADIX*WIDTH-1:0] i_data,
  input  reduce_op_t             i_op,
  output logic [WIDTH-1:0]       o_data
);

  always_comb begin
    o_data = {WIDTH{identity(i_op)}};
    for (int i = 0; i < RADIX; i++) begin
      case (i_op)
        OP_AND:  o_data = o_data & i_data[i*WIDTH +: WIDTH];
        OP_XOR:  o_data = o_data ^ i_data[i*WIDTH +: WIDTH];
        default: o_data = o_data | i_data[i*WIDTH +: WIDTH];
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/reduce_gate_pipe.sv
`default_nettype none
// reduce_gate_pipe: pipelined N_IN-operand OR/AND/XOR/NOR reduction with valid/ready (rev 1.0).
// Optional sticky result accumulator enabled by defining REDUCE_STICKY_ACC_EN.

module reduce_gate_pipe
  import reduce_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int WIDTH = 4,
  parameter int RADIX = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [1:0]            in_op,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  acc_clr,
  output logic [WIDTH-1:0]      acc_out
);

  localparam int STAGES = stages(N_IN, RADIX);
  localparam int BUS_W  = N_IN * WIDTH;

  logic             w_en;
  logic [BUS_W-1:0] w_bus_data  [STAGES+1];
  reduce_op_t       w_bus_op    [STAGES+1];
  logic             w_bus_valid [STAGES+1];
  logic             w_unused_tail;

  // Single global advance: the whole pipe moves or the whole pipe holds.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  assign w_bus_data[0]  = in_data;
  assign w_bus_op[0]    = reduce_op_t'(in_op);
  assign w_bus_valid[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_lvl
    localparam int N_PREV = level_inputs(N_IN, RADIX, k);
    localparam int N_CUR  = (N_PREV + RADIX - 1) / RADIX;
    localparam int N_PAD  = N_CUR * RADIX;

    logic [N_PAD*WIDTH-1:0] w_pad;
    logic [N_CUR*WIDTH-1:0] w_red;
    logic [N_CUR*WIDTH-1:0] w_res;
    logic [N_CUR*WIDTH-1:0] r_data;
    logic                   w_fill;
    reduce_op_t             r_op;
    logic                   r_valid;

    assign w_fill = identity(w_bus_op[k]);

    for (genvar g = 0; g < N_PAD; g++) begin : g_pad
      if (g < N_PREV) begin : g_src
        assign w_pad[g*WIDTH +: WIDTH] = w_bus_data[k][g*WIDTH +: WIDTH];
      end else begin : g_fill
        assign w_pad[g*WIDTH +: WIDTH] = {WIDTH{w_fill}};
      end
    end

    // Upper bus lanes above this level's operand count are constant zero.
    if (N_PREV < N_IN) begin : g_sink
      logic w_unused_hi;
      assign w_unused_hi = ^w_bus_data[k][BUS_W-1:N_PREV*WIDTH];
    end

    for (genvar g = 0; g < N_CUR; g++) begin : g_node
      reduce_node #(
        .RADIX (RADIX),
        .WIDTH (WIDTH)
      ) u_node (
        .i_data (w_pad[g*RADIX*WIDTH +: RADIX*WIDTH]),
        .i_op   (w_bus_op[k]),
        .o_data (w_red[g*WIDTH +: WIDTH])
      );
    end

    if (k == STAGES - 1) begin : g_final
      assign w_res = (w_bus_op[k] == OP_NOR) ? ~w_red : w_red;
    end else begin : g_mid
      assign w_res = w_red;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data  <= '0;
        r_op    <= OP_OR;
        r_valid <= 1'b0;
      end else if (w_en) begin
        r_data  <= w_res;
        r_op    <= w_bus_op[k];
        r_valid <= w_bus_valid[k];
      end
    end

    assign w_bus_data[k+1]  = {{((N_IN - N_CUR) * WIDTH){1'b0}}, r_data};
    assign w_bus_op[k+1]    = r_op;
    assign w_bus_valid[k+1] = r_valid;
  end

  assign out_data  = w_bus_data[STAGES][WIDTH-1:0];
  assign out_valid = w_bus_valid[STAGES];

  assign w_unused_tail = ^{w_bus_data[STAGES][BUS_W-1:WIDTH], w_bus_op[STAGES]};

`ifdef REDUCE_STICKY_ACC_EN
  logic             w_deliver;
  logic [WIDTH-1:0] r_acc;

  assign w_deliver = out_valid && out_ready;

  // Clear wins over history but not over a coincident delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= w_deliver ? out_data : '0;
    end else if (w_deliver) begin
      r_acc <= r_acc | out_data;
    end
  end

  assign acc_out = r_acc;
`else
  logic w_unused_acc;

  assign acc_out      = '0;
  assign w_unused_acc = acc_clr;
`endif

endmodule

`default_nettype wire
